// File: rtl/sseg_scan_decoder_if.sv
// Display-side bundle: driver lines in, rebuilt frame and flags out.
interface sseg_scan_decoder_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] value;
  logic [3:0]  dp_out;
  logic [3:0]  blank;
  logic [3:0]  invalid;
  logic        frame_valid;
  logic        ghost;

  modport master (
    output an, seg, dp,
    input  value, dp_out, blank, invalid,
    input  frame_valid, ghost
  );

  modport slave (
    input  an, seg, dp,
    output value, dp_out, blank, invalid,
    output frame_valid, ghost
  );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Rebuilds a 4-digit multiplexed seven-segment display into a
// 16-bit hex value with per-digit dp/blank/invalid flags.
module sseg_scan_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  sseg_scan_decoder_if.slave bus
);
  localparam logic [7:0] SAT = 8'(STABLE_CYCLES);
  localparam logic [7:0] HIT = 8'(STABLE_CYCLES - 2);

  logic [11:0] cur;
  logic [11:0] in_q;
  logic [7:0]  cnt;
  logic        same;
  logic        commit;
  logic        commit_q;
  logic [3:0]  q_an;
  logic [6:0]  q_seg;
  logic        q_dp;
  logic [3:0]  low;
  logic        multi;
  logic        single;
  logic [3:0]  nib;
  logic        blk;
  logic        inv;
  logic [3:0]  captured;
  logic [15:0] stg_val;
  logic [3:0]  stg_dp;
  logic [3:0]  stg_blank;
  logic [3:0]  stg_inv;

  assign cur    = {bus.an, bus.seg, bus.dp};
  assign q_an   = in_q[11:8];
  assign q_seg  = in_q[7:1];
  assign q_dp   = in_q[0];
  assign same   = (cur == in_q);
  // Fires once, on the edge that completes the stable window.
  assign commit = same && (cnt == HIT);
  assign low    = ~q_an;
  assign multi  = (low & (low - 4'd1)) != 4'd0;
  assign single = (low != 4'd0) && !multi;

  always_comb begin
    nib = 4'h0;
    blk = 1'b0;
    inv = 1'b0;
    case (q_seg)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      7'h7F: blk = 1'b1;
      default: inv = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      in_q            <= '0;
      cnt             <= '0;
      commit_q        <= 1'b0;
      captured        <= '0;
      stg_val         <= '0;
      stg_dp          <= '0;
      stg_blank       <= '0;
      stg_inv         <= '0;
      bus.value       <= '0;
      bus.dp_out      <= '0;
      bus.blank       <= '0;
      bus.invalid     <= '0;
      bus.frame_valid <= 1'b0;
      bus.ghost       <= 1'b0;
    end else begin
      in_q     <= cur;
      commit_q <= commit;
      if (!same)
        cnt <= '0;
      else if (cnt != SAT)
        cnt <= cnt + 8'd1;
      // in_q still holds the committed pattern one edge later
      bus.ghost       <= commit_q && multi;
      bus.frame_valid <= 1'b0;
      if (commit && single) begin
        for (int k = 0; k < 4; k++) begin
          if (!q_an[k]) begin
            stg_val[4*k +: 4] <= nib;
            stg_dp[k]         <= ~q_dp;
            stg_blank[k]      <= blk;
            stg_inv[k]        <= inv;
            captured[k]       <= 1'b1;
          end
        end
      end
      if (captured == 4'hF) begin
        bus.value       <= stg_val;
        bus.dp_out      <= stg_dp;
        bus.blank       <= stg_blank;
        bus.invalid     <= stg_inv;
        bus.frame_valid <= 1'b1;
        captured        <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder with STABLE_CYCLES = 4.
module tb_sseg_scan_decoder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  sseg_scan_decoder_if bus();

  sseg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  s3, s2, s1, s0;
    logic [3:0]  dpl;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  blank;
    logic [3:0]  invalid;
  } vec_t;

  logic [6:0] gly [16];
  vec_t vt [4];
  int n_cmp = 0;
  int n_err = 0;
  int fv_n = 0;
  int gh_n = 0;
  int both_n = 0;
  int fv0, gh0;

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) fv_n++;
    if (bus.ghost === 1'b1) gh_n++;
    if (bus.frame_valid === 1'b1 && bus.ghost === 1'b1) both_n++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic dig(input int k, input logic [6:0] s,
                     input logic dpl, input int cyc);
    bus.an  = ~(4'b0001 << k);
    bus.seg = s;
    bus.dp  = ~dpl;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int cyc);
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    bus.dp  = 1'b1;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic [15:0] v,
                         input logic [3:0] d, input logic [3:0] b,
                         input logic [3:0] i);
    chk({nm, "_value"}, 32'(bus.value), 32'(v));
    chk({nm, "_dp"}, 32'(bus.dp_out), 32'(d));
    chk({nm, "_blank"}, 32'(bus.blank), 32'(b));
    chk({nm, "_inv"}, 32'(bus.invalid), 32'(i));
  endtask

  initial begin
    gly[0] = 7'h40; gly[1] = 7'h79; gly[2] = 7'h24; gly[3] = 7'h30;
    gly[4] = 7'h19; gly[5] = 7'h12; gly[6] = 7'h02; gly[7] = 7'h78;
    gly[8] = 7'h00; gly[9] = 7'h10; gly[10] = 7'h08; gly[11] = 7'h03;
    gly[12] = 7'h46; gly[13] = 7'h21; gly[14] = 7'h06; gly[15] = 7'h0E;

    vt[0] = '{gly[1], gly[10], gly[2], gly[15], 4'b0100,
              16'h1A2F, 4'b0100, 4'b0000, 4'b0000};
    vt[1] = '{7'h55, gly[4], 7'h7F, gly[6], 4'b0000,
              16'h0406, 4'b0000, 4'b0010, 4'b1000};
    vt[2] = '{gly[0], gly[0], gly[0], gly[0], 4'b0000,
              16'h0000, 4'b0000, 4'b0000, 4'b0000};
    vt[3] = '{gly[8], gly[14], gly[3], gly[11], 4'b1001,
              16'h8E3B, 4'b1001, 4'b0000, 4'b0000};

    bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 16'h0, 4'h0, 4'h0, 4'h0);
    chk("rst_fv", 32'(bus.frame_valid), 32'd0);
    chk("rst_ghost", 32'(bus.ghost), 32'd0);
    reset_n = 1'b1;
    gap(3);

    for (int v = 0; v < 4; v++) begin
      fv0 = fv_n;
      dig(3, vt[v].s3, vt[v].dpl[3], 8);
      dig(2, vt[v].s2, vt[v].dpl[2], 8);
      dig(1, vt[v].s1, vt[v].dpl[1], 8);
      dig(0, vt[v].s0, vt[v].dpl[0], 8);
      gap(3);
      chk($sformatf("vec%0d_frames", v), 32'(fv_n - fv0), 32'd1);
      chk_out($sformatf("vec%0d", v), vt[v].value, vt[v].dp_out,
              vt[v].blank, vt[v].invalid);
    end

    // Digit 0 held only 3 cycles: must not commit
    fv0 = fv_n;
    dig(3, gly[1], 1'b0, 8);
    dig(2, gly[10], 1'b0, 8);
    dig(1, gly[2], 1'b0, 8);
    dig(0, gly[15], 1'b0, 3);
    gap(10);
    chk("glitch_frames", 32'(fv_n - fv0), 32'd0);
    chk_out("glitch_hold", 16'h8E3B, 4'b1001, 4'h0, 4'h0);

    // Two anodes low: one ghost pulse, staging untouched
    fv0 = fv_n; gh0 = gh_n;
    bus.an = 4'b1100; bus.seg = gly[8]; bus.dp = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    gap(4);
    chk("ghost_pulses", 32'(gh_n - gh0), 32'd1);
    chk("ghost_frames", 32'(fv_n - fv0), 32'd0);

    // Exactly 4 stable samples completes the pending frame
    fv0 = fv_n;
    dig(0, gly[7], 1'b0, 4);
    bus.an = 4'hF; bus.seg = 7'h7F; bus.dp = 1'b1;
    @(posedge clk); #1;
    chk("lat_fv_hi", 32'(bus.frame_valid), 32'd1);
    chk_out("lat", 16'h1A27, 4'h0, 4'h0, 4'h0);
    @(posedge clk); #1;
    chk("lat_fv_lo", 32'(bus.frame_valid), 32'd0);
    gap(2);
    chk("lat_frames", 32'(fv_n - fv0), 32'd1);

    // Recapture: latest digit 0 wins
    fv0 = fv_n;
    dig(0, gly[5], 1'b0, 8);
    dig(1, gly[7], 1'b0, 8);
    dig(0, gly[9], 1'b0, 8);
    dig(2, gly[8], 1'b0, 8);
    dig(3, gly[8], 1'b0, 8);
    gap(3);
    chk("recap_frames", 32'(fv_n - fv0), 32'd1);
    chk("recap_value", 32'(bus.value), 32'h8879);

    // Reset mid-frame discards the partial capture
    fv0 = fv_n;
    dig(3, gly[1], 1'b1, 8);
    dig(2, gly[2], 1'b0, 8);
    dig(1, gly[3], 1'b0, 8);
    gap(2);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk_out("mid_rst", 16'h0, 4'h0, 4'h0, 4'h0);
    dig(3, gly[4], 1'b0, 8);
    gap(4);
    chk("mid_rst_frames", 32'(fv_n - fv0), 32'd0);
    chk_out("mid_rst_hold", 16'h0, 4'h0, 4'h0, 4'h0);
    dig(2, gly[5], 1'b0, 8);
    dig(1, gly[6], 1'b0, 8);
    dig(0, gly[7], 1'b1, 8);
    gap(3);
    chk("post_rst_frames", 32'(fv_n - fv0), 32'd1);
    chk_out("post_rst", 16'h4567, 4'b0001, 4'h0, 4'h0);

    chk("pulse_overlap", 32'(both_n), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sseg_scan_decoder.md
# sseg_scan_decoder

Receive-side counterpart to the 4-digit multiplexed seven-segment driver. The block watches the anode, segment and decimal-point lines the driver produces and rebuilds the displayed 16-bit hex value plus per-digit flags. A full frame is reported once all four digits have been captured. It is used for board-level loopback self-test and as a bench monitor, in the same clock domain as the driver.

## Interface
- STABLE_CYCLES, 16, number of consecutive identical samples required before a digit is accepted; legal range 2..255.
- clk  input  1  system clock; all logic rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- an  input  4  anode enables, active-low; an[0] = rightmost digit (digit 0), an[3] = leftmost.
- seg  input  7  cathodes, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
- dp  input  1  decimal point, active-low.
- value  output  16  decoded digits; value[4k+3:4k] = digit k.
- dp_out  output  4  dp_out[k] = 1 if the dp of digit k was lit.
- blank  output  4  blank[k] = 1 if digit k was all segments off (seg = 7'h7F).
- invalid  output  4  invalid[k] = 1 if the seg pattern of digit k is not a legal hex glyph or blank.
- frame_valid  output  1  one-cycle pulse; value, dp_out, blank and invalid updated this cycle.
- ghost  output  1  one-cycle pulse; a stable window with more than one anode low was rejected.

## Operation
- No input synchronizer. The inputs come from the same clock domain.
- The input register in_q holds {an,seg,dp} and loads every cycle.
- Stability counter cnt, 8 bits:
  - Clears to 0 when the current {an,seg,dp} differs from in_q.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Commit event: fires on the single cycle cnt reaches STABLE_CYCLES-1. This means the inputs have been identical across STABLE_CYCLES consecutive edges. It fires only once per stable window.
- At a commit, the action depends on in_q.an:
  - Exactly one bit low (4'b1110, 1101, 1011, 0111): digit k is accepted. Its nibble and its dp, blank and invalid bits go into staging registers, and captured[k] is set.
  - 4'b1111: nothing is recorded and nothing is flagged.
  - Two or more bits low: ghost pulses, and nothing is recorded.
- Glyph decode, active-low hex patterns:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - 7F: blank, nibble 0.
  - Any other pattern: invalid, nibble 0.
  - dp is independent of the seg decode.
- Recapture: if digit k is committed again before the frame completes, its staging entry is overwritten. The latest value wins.
- Frame completion: when captured becomes 4'b1111, the four staging entries are copied to the outputs as one group. frame_valid pulses and captured clears to 0.
  - If a commit fills the last missing digit, the copy includes that digit.
- Between frames, outputs hold their last values.
- Reset (reset_n = 0 at a clock edge) clears to 0: in_q, cnt, captured, staging, value, dp_out, blank, invalid, frame_valid and ghost.
  - Reset mid-frame discards any partial capture.
  - After reset is released, a digit needs a fresh full stable window to be captured.

## Timing
- All outputs are registered. Their reset value is 0.
- Digit acceptance latency: a new {an,seg,dp} first appears at edge E0, at which point cnt clears. The commit fires at edge E0+STABLE_CYCLES-1. This equals STABLE_CYCLES identical samples, E0 included.
- frame_valid and the updated outputs appear at the edge after the completing commit. A ghost pulse also appears at the edge after its rejected commit.
- The two pulses never last more than 1 cycle. frame_valid and ghost never assert in the same cycle.
- Glitch rejection: an input change shorter than STABLE_CYCLES cycles produces no commit. Blanking gaps between digits (an = 1111) are ignored regardless of their length.
- Steady input: cnt saturates and no repeat commit occurs. A display showing a single digit forever never completes a frame.
- Minimum frame time: 4 × STABLE_CYCLES cycles, plus 1 cycle of output latency.

## Test plan
- STABLE_CYCLES=4. Drive digits 3,2,1,0 as 7-seg glyphs for "1A2F", 8 cycles each, with dp lit on digit 2.
  - Required: one frame_valid, value=16'h1A2F, dp_out=4'b0100, blank=0, invalid=0.
- Drive the digit 0 pattern for only 3 cycles inside an otherwise valid frame, then return to an=1111.
  - Required: digit 0 is not captured, frame_valid stays low, and outputs hold their prior frame.
- Drive seg=7'h7F on digit 1 and seg=7'h55 on digit 3, with legal glyphs elsewhere.
  - Required: blank=4'b0010, invalid=4'b1000, nibbles 1 and 3 equal 0.
- Drive an=4'b1100 stable for 6 cycles.
  - Required: a single ghost pulse and no change to captured.
  - Then complete a normal frame "0000". Required: frame_valid with value=0.
- Capture digits 0 and 1 as "5" and "7", recapture digit 0 as "9", then capture digits 2 and 3 as "8".
  - Required: value=16'h8879.
- Capture 3 digits, assert reset_n=0 for 1 cycle, then capture only digit 3.
  - Required: all outputs read 0 after reset and no frame_valid. The next 4 digits complete a frame normally.
